// File: rtl/controle_manobra.sv
// Timed manoeuvre sequencer for the obstacle-avoiding robot: reverse, turn with
// retries, then error. All outputs are registered and power-gated.
module controle_manobra #(
  parameter int RE_CICLOS   = 8,
  parameter int GIRO_CICLOS = 4,
  parameter int MAX_GIROS   = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Ligar,
  input  logic       Bateria,
  input  logic       Sensor_Frontal,
  input  logic       Sensor_Direito,
  input  logic       Sensor_Esquerdo,
  input  logic       Sensor_Trazeiro,
  output logic       Motor_Frente,
  output logic       Motor_Re,
  output logic       Gira_Direita,
  output logic       Gira_Esquerda,
  output logic       Saida_Erro,
  output logic       Saida_Re,
  output logic       Saida_Girar,
  output logic       RoboLigado,
  output logic [2:0] Estado
);
  localparam int CMAX = (RE_CICLOS > GIRO_CICLOS) ? RE_CICLOS : GIRO_CICLOS;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int TW   = (MAX_GIROS > 1) ? $clog2(MAX_GIROS) : 1;
  localparam logic [CW-1:0] RE_INI    = CW'(RE_CICLOS - 1);
  localparam logic [CW-1:0] GIRO_INI  = CW'(GIRO_CICLOS - 1);
  localparam logic [TW-1:0] TENT_ULT  = TW'(MAX_GIROS - 1);

  typedef enum logic [2:0] {
    DESLIGADO = 3'd0,
    FRENTE    = 3'd1,
    RE        = 3'd2,
    GIRO      = 3'd3,
    ERRO      = 3'd4
  } estado_t;

  estado_t       st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tent, tent_n;
  logic          dir, dir_n;   // 1 = left

  logic liga, dir_pick, todos, nenhum;
  assign liga     = Ligar & ~Bateria;
  // Turn left only when right is blocked and left is clear; otherwise right.
  assign dir_pick = Sensor_Direito & ~Sensor_Esquerdo;
  assign todos    = Sensor_Frontal & Sensor_Direito & Sensor_Esquerdo & Sensor_Trazeiro;
  assign nenhum   = ~(Sensor_Frontal | Sensor_Direito | Sensor_Esquerdo | Sensor_Trazeiro);

  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    tent_n = tent;
    dir_n  = dir;
    if (!liga) begin
      st_n   = DESLIGADO;
      cnt_n  = '0;
      tent_n = '0;
    end else begin
      case (st)
        DESLIGADO: st_n = FRENTE;
        FRENTE: begin
          if (todos) begin
            st_n = ERRO;
          end else if (Sensor_Frontal && !Sensor_Trazeiro) begin
            st_n   = RE;
            cnt_n  = RE_INI;
            tent_n = '0;
          end else if (Sensor_Frontal && Sensor_Trazeiro) begin
            st_n   = GIRO;
            cnt_n  = GIRO_INI;
            tent_n = '0;
            dir_n  = dir_pick;
          end
        end
        RE: begin
          if (Sensor_Trazeiro || cnt == '0) begin
            st_n  = GIRO;
            cnt_n = GIRO_INI;
            dir_n = dir_pick;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        GIRO: begin
          if (cnt != '0) begin
            cnt_n = cnt - CW'(1);
          end else if (!Sensor_Frontal) begin
            st_n   = FRENTE;
            tent_n = '0;
          end else if (tent == TENT_ULT) begin
            st_n   = ERRO;
            tent_n = '0;
          end else begin
            tent_n = tent + TW'(1);
            cnt_n  = GIRO_INI;
            dir_n  = dir_pick;
          end
        end
        ERRO: if (nenhum) st_n = FRENTE;
        default: begin
          st_n   = DESLIGADO;
          cnt_n  = '0;
          tent_n = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      st            <= DESLIGADO;
      cnt           <= '0;
      tent          <= '0;
      dir           <= 1'b0;
      Motor_Frente  <= 1'b0;
      Motor_Re      <= 1'b0;
      Gira_Direita  <= 1'b0;
      Gira_Esquerda <= 1'b0;
      Saida_Erro    <= 1'b0;
      Saida_Re      <= 1'b0;
      Saida_Girar   <= 1'b0;
      RoboLigado    <= 1'b0;
    end else begin
      st            <= st_n;
      cnt           <= cnt_n;
      tent          <= tent_n;
      dir           <= dir_n;
      Motor_Frente  <= (st_n == FRENTE);
      Motor_Re      <= (st_n == RE);
      Gira_Direita  <= (st_n == GIRO) && !dir_n;
      Gira_Esquerda <= (st_n == GIRO) && dir_n;
      Saida_Erro    <= (st_n == ERRO);
      Saida_Re      <= (st_n == RE);
      Saida_Girar   <= (st_n == GIRO);
      RoboLigado    <= liga;
    end
  end

  assign Estado = st;
endmodule

// File: tb/tb_controle_manobra.sv
// Scoreboard bench for controle_manobra: directed steps push the expected output
// word; a monitor pops and compares one word after every rising edge.
module tb_controle_manobra;
  logic clk = 1'b0;
  logic rst, ligar, bat, sf, sd, se, st;
  logic m_fr, m_re, g_d, g_e, s_erro, s_re, s_gir, robo;
  logic [2:0] estado;

  int n_vec = 0;
  int n_err = 0;
  logic [10:0] q[$];

  controle_manobra #(.RE_CICLOS(3), .GIRO_CICLOS(2), .MAX_GIROS(2)) dut (
    .Clock(clk), .Reset(rst), .Ligar(ligar), .Bateria(bat),
    .Sensor_Frontal(sf), .Sensor_Direito(sd), .Sensor_Esquerdo(se), .Sensor_Trazeiro(st),
    .Motor_Frente(m_fr), .Motor_Re(m_re), .Gira_Direita(g_d), .Gira_Esquerda(g_e),
    .Saida_Erro(s_erro), .Saida_Re(s_re), .Saida_Girar(s_gir),
    .RoboLigado(robo), .Estado(estado)
  );

  always #5 clk = ~clk;

  // Word: {Estado, RoboLigado, Frente, Re, GiraD, GiraE, Erro, SaidaRe, Girar}
  function automatic logic [10:0] mk(input logic [2:0] s, input logic left, input logic rl);
    logic [6:0] o;
    case (s)
      3'd1:    o = 7'b1000000;
      3'd2:    o = 7'b0100010;
      3'd3:    o = left ? 7'b0001001 : 7'b0010001;
      3'd4:    o = 7'b0000100;
      default: o = 7'b0000000;
    endcase
    return {s, rl, o};
  endfunction

  // sen = {Frontal, Direito, Esquerdo, Trazeiro}
  task automatic step(input logic r, input logic l, input logic b, input logic [3:0] sen,
                      input logic [2:0] s, input logic left, input logic rl);
    rst = r; ligar = l; bat = b;
    {sf, sd, se, st} = sen;
    q.push_back(mk(s, left, rl));
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [10:0] act, exp_w;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        exp_w = q.pop_front();
        act = {estado, robo, m_fr, m_re, g_d, g_e, s_erro, s_re, s_gir};
        n_vec++;
        if (act !== exp_w) begin
          n_err++;
          $display("FAIL vec%0d: got %b expected %b", n_vec, act, exp_w);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ligar = 1'b0; bat = 1'b0; {sf, sd, se, st} = 4'b0000;
    // Reset for two cycles: everything 0.
    step(1, 0, 0, 4'b0000, 3'd0, 0, 0);
    step(1, 0, 0, 4'b0000, 3'd0, 0, 0);
    // Power on.
    step(0, 1, 0, 4'b0000, 3'd1, 0, 1);
    step(0, 1, 0, 4'b0000, 3'd1, 0, 1);
    // One-cycle frontal pulse: 3 RE, 2 GIRO right, back to FRENTE.
    step(0, 1, 0, 4'b1000, 3'd2, 0, 1);
    step(0, 1, 0, 4'b0000, 3'd2, 0, 1);
    step(0, 1, 0, 4'b0000, 3'd2, 0, 1);
    step(0, 1, 0, 4'b0000, 3'd3, 0, 1);
    step(0, 1, 0, 4'b0000, 3'd3, 0, 1);
    step(0, 1, 0, 4'b0000, 3'd1, 0, 1);
    // Frontal held, right blocked: 3 RE, 2+2 GIRO left, ERRO.
    step(0, 1, 0, 4'b1100, 3'd2, 0, 1);
    step(0, 1, 0, 4'b1100, 3'd2, 0, 1);
    step(0, 1, 0, 4'b1100, 3'd2, 0, 1);
    step(0, 1, 0, 4'b1100, 3'd3, 1, 1);
    step(0, 1, 0, 4'b1100, 3'd3, 1, 1);
    step(0, 1, 0, 4'b1100, 3'd3, 1, 1);
    step(0, 1, 0, 4'b1100, 3'd3, 1, 1);
    step(0, 1, 0, 4'b1100, 3'd4, 0, 1);
    step(0, 1, 0, 4'b1000, 3'd4, 0, 1);
    step(0, 1, 0, 4'b0000, 3'd1, 0, 1);
    // Trazeiro during RE cycle 2 cuts reverse short.
    step(0, 1, 0, 4'b1000, 3'd2, 0, 1);
    step(0, 1, 0, 4'b0000, 3'd2, 0, 1);
    step(0, 1, 0, 4'b0001, 3'd3, 0, 1);
    step(0, 1, 0, 4'b0000, 3'd3, 0, 1);
    // Low battery mid-GIRO drops to DESLIGADO, then recovery.
    step(0, 1, 1, 4'b0000, 3'd0, 0, 0);
    step(0, 1, 1, 4'b0000, 3'd0, 0, 0);
    step(0, 1, 0, 4'b0000, 3'd1, 0, 1);
    // Retry count restarted: full 3 RE + 2x2 GIRO before ERRO; both sides blocked -> right.
    step(0, 1, 0, 4'b1110, 3'd2, 0, 1);
    step(0, 1, 0, 4'b1110, 3'd2, 0, 1);
    step(0, 1, 0, 4'b1110, 3'd2, 0, 1);
    step(0, 1, 0, 4'b1110, 3'd3, 0, 1);
    step(0, 1, 0, 4'b1110, 3'd3, 0, 1);
    step(0, 1, 0, 4'b1110, 3'd3, 0, 1);
    step(0, 1, 0, 4'b1110, 3'd3, 0, 1);
    step(0, 1, 0, 4'b1110, 3'd4, 0, 1);
    step(0, 1, 0, 4'b0000, 3'd1, 0, 1);
    // Front and back blocked: straight to GIRO, left clear.
    step(0, 1, 0, 4'b1101, 3'd3, 1, 1);
    step(0, 1, 0, 4'b0000, 3'd3, 1, 1);
    step(0, 1, 0, 4'b0000, 3'd1, 0, 1);
    // All four sensors: FRENTE -> ERRO directly.
    step(0, 1, 0, 4'b1111, 3'd4, 0, 1);
    step(0, 1, 0, 4'b1111, 3'd4, 0, 1);
    step(0, 1, 0, 4'b0000, 3'd1, 0, 1);
    // Switch off mid-RE.
    step(0, 1, 0, 4'b1000, 3'd2, 0, 1);
    step(0, 0, 0, 4'b0000, 3'd0, 0, 0);
    step(0, 1, 0, 4'b0000, 3'd1, 0, 1);
    // Reset while running.
    step(1, 1, 0, 4'b0000, 3'd0, 0, 0);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected words left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
